mem_responder: RTL
==================

# mem_responder

Block-level memory responder for the processor cache's memory port. It accepts one read or write request at a time from the cache (`mem_read`/`mem_write`, 28-bit block address, 128-bit block data). After a fixed programmable latency it completes the request with a single-cycle `mem_ready` pulse, returning block data on reads. It stands in for the main memory behind the cache in block-level and system simulation, and is the responder end of the cache's memory handshake.

## Interface
- `LATENCY`, default 8: edges from request capture to `mem_ready` rise; legal range 1..255.
- `ADDR_BITS`, default 8: number of low block-address bits used to index storage; depth is 2^ADDR_BITS blocks.
- `clk`  input  1  clock; all state changes on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `mem_read`  input  1  block read request from the cache; level, held until `mem_ready` is seen.
- `mem_write`  input  1  block write request from the cache; level, held until `mem_ready` is seen.
- `mem_addr`  input  28  block address (word address >> 2).
- `mem_wdata`  input  128  write block data.
- `mem_rdata`  output  128  read block data; valid only while `mem_ready`=1.
- `mem_ready`  output  1  completion pulse, one cycle wide.

## Operation
- Storage: 2^ADDR_BITS x 128-bit array, indexed by `mem_addr[ADDR_BITS-1:0]`. Upper address bits are ignored, so addresses alias modulo depth.
- States:
  - IDLE: waiting for a request.
  - BUSY: latency countdown.
  - READY: one-cycle completion.
- IDLE: on an edge with `mem_read` or `mem_write` high, latch op, index and `mem_wdata`, then load the latency counter.
  - LATENCY=1: go to READY.
  - Otherwise: go to BUSY.
- BUSY: decrement the counter each edge. Go to READY on the edge that completes LATENCY edges since capture.
- Requester inputs are not sampled in BUSY or READY. Changes to `mem_addr`, `mem_wdata` or the request bits during BUSY have no effect.
- READY: `mem_ready`=1 for exactly one cycle, then return unconditionally to IDLE. The cache drops its request combinationally during this cycle, so the READY->IDLE edge must not capture.
- Write: the array entry is updated on the edge entering READY, using the latched data.
- Read: `mem_rdata` is registered on the edge entering READY, from the latched index. It holds the array contents as of that edge.
- Both `mem_read` and `mem_write` high at capture: treated as a write and the read is ignored. The cache never does this.
- `mem_rdata` is 0 in every cycle where `mem_ready`=0, and 0 during READY for a write.
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE; counter, latches, `mem_ready` and `mem_rdata` go to 0 immediately.
  - All array entries are cleared to 0.
  - An in-flight request is abandoned; a pending write is not committed.
- Reset release: the first capture can occur on the first rising edge with `rst_n`=1.

## Timing
- Capture edge E0 (request high, state IDLE).
- `mem_ready` rises at E0+LATENCY and falls at E0+LATENCY+1.
- Next capture is possible at E0+LATENCY+2 at the earliest. Back-to-back requests are therefore separated by one IDLE cycle.
- A cache write-back followed by a refill takes 2*LATENCY+2 cycles from first capture to refill completion.
- No combinational path from inputs to outputs; all outputs are registered.
- Throughput is one request per LATENCY+2 cycles, with no queuing.

## Test plan
- Reset: hold `rst_n`=0 with random inputs and clock running -> `mem_ready`=0 and `mem_rdata`=0 throughout. Deassert with no request -> both stay 0.
- Write then read, LATENCY=8: write addr 28'h0000005 with data 128'hA5A5...A5 held until ready -> `mem_ready` high only in the cycle after E0+8. Then read 28'h0000005 -> `mem_ready` one cycle with `mem_rdata`=128'hA5A5...A5; `mem_rdata`=0 in all other cycles.
- Unwritten/alias: read 28'h0000010 after reset -> 0. With ADDR_BITS=8, write 28'h0000100 = 128'h1234 -> a read of 28'h0000000 returns 128'h1234.
- Cache-style write-back + refill: write 28'h0000003 (data D1), then raise `mem_read` at 28'h0000023 in the cycle right after `mem_ready` -> write completes at E0+8, read captured at E0+10 and completes at E0+18. A later read of 28'h0000003 returns D1.
- Input change in BUSY: after capturing a read of 28'h0000001, change `mem_addr` to 28'h0000002 and raise `mem_write` -> data for 28'h0000001 is returned and no write occurs.
- Reset mid-operation: capture a write of 28'h0000007 = 128'hFF, assert `rst_n`=0 at E0+3 -> `mem_ready` never rises for it. After release, a read of 28'h0000007 returns 0. Repeat with LATENCY=1 -> `mem_ready` rises on the edge after capture.

Source files
------------

// File: rtl/mem_responder.sv
// Block memory responder for the cache memory port: one request at a time,
// completed with a one-cycle mem_ready pulse a fixed LATENCY edges after capture.
module mem_responder #(
   parameter int LATENCY   = 8,
   parameter int ADDR_BITS = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [27:0]  mem_addr,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_ready
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   // Remaining BUSY edges after capture; READY is entered when this reaches zero.
   localparam logic [7:0] LOAD = 8'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, READY} state_t;

   state_t                 state, state_next;
   logic [7:0]             count, count_next;
   logic                   capture;
   logic                   enter_ready;
   logic                   op_write;
   logic [ADDR_BITS-1:0]   index;
   logic [127:0]           wdata_q;
   logic [127:0]           mem [DEPTH];

   // Upper block-address bits alias and are deliberately dropped.
   logic unused_addr;
   assign unused_addr = ^mem_addr[27:ADDR_BITS];

   always_comb begin
      state_next  = state;
      count_next  = count;
      capture     = 1'b0;
      enter_ready = 1'b0;
      case (state)
         IDLE: begin
            if (mem_read || mem_write) begin
               capture    = 1'b1;
               state_next = BUSY;
               count_next = LOAD;
            end
         end
         BUSY: begin
            if (count == 8'd0) begin
               state_next  = READY;
               enter_ready = 1'b1;
            end else begin
               count_next = count - 8'd1;
            end
         end
         READY:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         op_write  <= 1'b0;
         index     <= '0;
         wdata_q   <= '0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         state     <= state_next;
         count     <= count_next;
         mem_ready <= enter_ready;
         if (capture) begin
            // A simultaneous read+write request is treated as a write.
            op_write <= mem_write;
            index    <= mem_addr[ADDR_BITS-1:0];
            wdata_q  <= mem_wdata;
         end
         if (enter_ready && !op_write)
            mem_rdata <= mem[index];
         else
            mem_rdata <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (enter_ready && op_write) begin
         mem[index] <= wdata_q;
      end
   end

endmodule
